chaser_sequencer: RTL and testbench

Upstream stage of the 3-bit-to-7-line one-hot LED decoder. It generates the 3-bit position code that the decoder turns into a single lit LED.
- Paced by an internal clock prescaler.
- Supports wrap-up, wrap-down, bounce ("Knight Rider") and hold modes, plus manual single-stepping and blanking.
- Code 0 is reserved for "all LEDs off". Active positions are 1..MAX_CODE.

---
 rtl/chaser_pkg.sv | 17 +
 rtl/tick_divider.sv | 35 +++
 rtl/chaser_sequencer.sv | 98 +++++++++
 tb/tb_chaser_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chaser_pkg.sv
// Shared constants for the LED chaser: mode encodings, reserved codes and direction values.
package chaser_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP_UP   = 2'b00,
    MODE_WRAP_DOWN = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  localparam int unsigned CODE_BLANK = 0;
  localparam int unsigned CODE_MIN   = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: pulses tick for one cycle each time the count wraps.
// The count freezes (not clears) while en is low.
module tick_divider #(
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(TICK_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/chaser_sequencer.sv
// Generates the position code for the one-hot LED decoder: wrap-up, wrap-down,
// bounce and hold modes, advanced by prescaler ticks or manual step edges.
module chaser_sequencer
  import chaser_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12000000,
  parameter int unsigned DIV_WIDTH  = 24,
  parameter int unsigned CODE_WIDTH = 3,
  parameter int unsigned MAX_CODE   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  step,
  input  logic                  blank,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  dir,
  output logic                  tick
);

  localparam logic [CODE_WIDTH-1:0] POS_MIN = CODE_WIDTH'(CODE_MIN);
  localparam logic [CODE_WIDTH-1:0] POS_MAX = CODE_WIDTH'(MAX_CODE);
  localparam logic [CODE_WIDTH-1:0] POS_ONE = CODE_WIDTH'(1);
  localparam logic [CODE_WIDTH-1:0] POS_OFF = CODE_WIDTH'(CODE_BLANK);

  logic [CODE_WIDTH-1:0] pos;
  logic [CODE_WIDTH-1:0] pos_nxt;
  logic                  dir_nxt;
  logic                  step_q;
  logic                  advance;

  tick_divider #(
    .TICK_DIV  (TICK_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // A tick registered just before en dropped is still honoured as an advance.
  assign advance = tick | (~en & step & ~step_q);

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (advance) begin
      case (mode_e'(mode))
        MODE_WRAP_UP: begin
          pos_nxt = (pos >= POS_MAX) ? POS_MIN : pos + POS_ONE;
          dir_nxt = DIR_UP;
        end
        MODE_WRAP_DOWN: begin
          pos_nxt = (pos <= POS_MIN) ? POS_MAX : pos - POS_ONE;
          dir_nxt = DIR_DOWN;
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (pos >= POS_MAX) begin
              pos_nxt = POS_MAX - POS_ONE;
              dir_nxt = DIR_DOWN;
            end else begin
              pos_nxt = pos + POS_ONE;
            end
          end else begin
            if (pos <= POS_MIN) begin
              pos_nxt = POS_MIN + POS_ONE;
              dir_nxt = DIR_UP;
            end else begin
              pos_nxt = pos - POS_ONE;
            end
          end
        end
        default: begin
          pos_nxt = pos;
          dir_nxt = dir;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= POS_MIN;
      dir    <= DIR_UP;
      code   <= POS_MIN;
      step_q <= 1'b0;
    end else begin
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      code   <= blank ? POS_OFF : pos;
      step_q <= step;
    end
  end

endmodule

// File: tb/tb_chaser_sequencer.sv
// Self-checking bench for chaser_sequencer with TICK_DIV=4, MAX_CODE=7.
module tb_chaser_sequencer;

  localparam int TD   = 4;
  localparam int MAXC = 7;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       step;
  logic       blank;
  logic [2:0] code;
  logic       dir;
  logic       tick;

  int errors;
  int checks;

  // reference model state
  int m_cnt;
  int m_pos;
  int m_code;
  bit m_dir;
  bit m_tick;
  bit m_stepq;

  chaser_sequencer #(
    .TICK_DIV   (TD),
    .DIV_WIDTH  (3),
    .CODE_WIDTH (3),
    .MAX_CODE   (MAXC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .step  (step),
    .blank (blank),
    .code  (code),
    .dir   (dir),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_advance();
    int n;
    case (mode)
      2'd0: begin m_pos = m_pos % MAXC + 1; m_dir = 1'b1; end
      2'd1: begin m_pos = (m_pos + MAXC - 2) % MAXC + 1; m_dir = 1'b0; end
      2'd2: begin
        n = m_dir ? m_pos + 1 : m_pos - 1;
        if (n > MAXC) begin n = MAXC - 1; m_dir = 1'b0; end
        else if (n < 1) begin n = 2; m_dir = 1'b1; end
        m_pos = n;
      end
      default: ;
    endcase
  endtask

  // One clock edge; the model sees the same inputs the DUT sampled.
  task automatic cycle();
    bit adv;
    bit wrap;
    @(posedge clk);
    adv = m_tick || (!en && step && !m_stepq);
    if (rst) begin
      m_cnt = 0; m_tick = 1'b0; m_pos = 1; m_dir = 1'b1; m_code = 1; m_stepq = 1'b0;
    end else begin
      m_code = blank ? 0 : m_pos;
      if (en) begin
        wrap   = (m_cnt == TD - 1);
        m_cnt  = wrap ? 0 : m_cnt + 1;
        m_tick = wrap;
      end else begin
        m_tick = 1'b0;
      end
      m_stepq = step;
      if (adv) model_advance();
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_code_change(output bit ok);
    logic [2:0] c0;
    c0 = code;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (code !== c0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; en = 1'b1; mode = 2'd0; step = 1'b0; blank = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    checks++; if (code !== 3'd1) begin errors++; $display("FAIL reset_code: got %0d expected 1", code); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %0b expected 1", dir); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", tick); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 0; i < 10; i++) begin
        cycle(); n++;
        if (tick === 1'b1) break;
      end
      checks++; if (n != TD) begin errors++; $display("FAIL tick_period%0d: got %0d cycles expected %0d", k, n, TD); end
    end
  endtask

  task automatic test_wrap_up();
    bit ok;
    int e;
    mode = 2'd0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      e = (k + 1) % MAXC + 1;
      wait_code_change(ok);
      checks++;
      if (!ok || code !== 3'(e)) begin errors++; $display("FAIL wrap_up[%0d]: got %0d (changed=%0b) expected %0d", k, code, ok, e); end
    end
  endtask

  task automatic test_wrap_down();
    bit ok;
    int e;
    mode = 2'd1;
    for (int k = 0; k < 8; k++) begin
      e = (k < 7) ? 7 - k : 7;
      wait_code_change(ok);
      checks++;
      if (!ok || code !== 3'(e)) begin errors++; $display("FAIL wrap_down[%0d]: got %0d (changed=%0b) expected %0d", k, code, ok, e); end
      if (k == 0) begin
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_down_dir: got %0b expected 0", dir); end
      end
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int seq [14];
    bit dseq [14];
    seq  = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 2, 3};
    dseq = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    mode = 2'd0;
    do_reset();
    mode = 2'd2;
    for (int k = 0; k < 14; k++) begin
      wait_code_change(ok);
      checks++;
      if (!ok || code !== 3'(seq[k]) || dir !== dseq[k]) begin
        errors++;
        $display("FAIL bounce[%0d]: got code=%0d dir=%0b (changed=%0b) expected code=%0d dir=%0b", k, code, dir, ok, seq[k], dseq[k]);
      end
    end
  endtask

  task automatic test_step();
    int n;
    mode = 2'd0; en = 1'b1; step = 1'b0;
    do_reset();
    cycle();
    cycle();
    en = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL step_tick_hi[%0d]: got %0b expected 0", i, tick); end
    end
    checks++; if (code !== 3'd2) begin errors++; $display("FAIL step_first: got %0d expected 2", code); end
    step = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    step = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    step = 1'b0;
    cycle();
    checks++; if (code !== 3'd3) begin errors++; $display("FAIL step_second: got %0d expected 3", code); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL step_tick_lo: got %0b expected 0", tick); end
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(); n++;
      if (tick === 1'b1) break;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL step_resume_tick: got %0d cycles expected 2", n); end
  endtask

  task automatic test_blank();
    bit ok;
    int nt;
    mode = 2'd0; en = 1'b1; step = 1'b0; blank = 1'b0;
    do_reset();
    wait_code_change(ok);
    wait_code_change(ok);
    checks++; if (code !== 3'd3) begin errors++; $display("FAIL blank_start: got %0d expected 3", code); end
    blank = 1'b1;
    nt = 0;
    for (int i = 0; i < 20 && nt < 3; i++) begin
      cycle();
      if (tick === 1'b1) nt++;
      checks++; if (code !== 3'd0) begin errors++; $display("FAIL blank_on[%0d]: got %0d expected 0", i, code); end
    end
    checks++; if (nt != 3) begin errors++; $display("FAIL blank_ticks: got %0d expected 3", nt); end
    cycle();
    blank = 1'b0;
    cycle();
    checks++; if (code !== 3'd6) begin errors++; $display("FAIL blank_release: got %0d expected 6", code); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    mode = 2'd0; en = 1'b1;
    do_reset();
    mode = 2'd2;
    for (int k = 0; k < 8; k++) wait_code_change(ok);
    checks++; if (code !== 3'd5 || dir !== 1'b0) begin errors++; $display("FAIL midrst_pre: got code=%0d dir=%0b expected code=5 dir=0", code, dir); end
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (code !== 3'd1 || dir !== 1'b1 || tick !== 1'b0) begin
      errors++; $display("FAIL midrst_post: got code=%0d dir=%0b tick=%0b expected 1 1 0", code, dir, tick);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(); n++;
      if (tick === 1'b1) break;
    end
    checks++; if (n != TD) begin errors++; $display("FAIL midrst_tick: got %0d cycles expected %0d", n, TD); end
  endtask

  task automatic test_random();
    logic [2:0] ec;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 23) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) step = ~step;
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      cycle();
      ec = 3'(m_code);
      checks++;
      if (code !== ec || dir !== m_dir || tick !== m_tick) begin
        errors++;
        $display("FAIL random[%0d]: got code=%0d dir=%0b tick=%0b expected code=%0d dir=%0b tick=%0b",
                 i, code, dir, tick, ec, m_dir, m_tick);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    m_cnt = 0; m_pos = 1; m_code = 1; m_dir = 1'b1; m_tick = 1'b0; m_stepq = 1'b0;
    rst = 1'b1; en = 1'b1; mode = 2'd0; step = 1'b0; blank = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_bounce();
    test_step();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
